// File: rtl/downstream_vc_tracker.sv
// Tracks allocation state and credit count of every downstream VC of a router.
// Optional protocol checking (sticky error_o) is built when DOWNSTREAM_VC_TRACKER_ERR_EN is defined.
module downstream_vc_tracker #(
    parameter int PORT_NUM    = 5,
    parameter int VC_NUM      = 2,
    parameter int VC_TOTAL    = 10,
    parameter int BUFFER_SIZE = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [VC_TOTAL-1:0]               vc_alloc_i,
    input  logic [PORT_NUM-1:0]               flit_valid_i,
    input  logic [PORT_NUM*$clog2(VC_NUM)-1:0] flit_vc_i,
    input  logic [PORT_NUM-1:0]               flit_tail_i,
    input  logic [PORT_NUM-1:0]               credit_valid_i,
    input  logic [PORT_NUM*$clog2(VC_NUM)-1:0] credit_vc_i,
    output logic [VC_TOTAL-1:0]               idle_downstream_vc_o,
    output logic [VC_TOTAL-1:0]               credit_avail_o,
    output logic                              error_o
);

    localparam int VC_SIZE = $clog2(VC_NUM);
    localparam int CNT_W   = $clog2(BUFFER_SIZE + 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACTIVE   = 2'd1;
    localparam logic [1:0] DRAINING = 2'd2;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_SIZE);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

`ifdef DOWNSTREAM_VC_TRACKER_ERR_EN
    logic [VC_TOTAL-1:0] vc_err;
`endif

    for (genvar d = 0; d < VC_TOTAL; d++) begin : g_vc
        localparam int P = d / VC_NUM;
        localparam int V = d % VC_NUM;

        logic             sent;
        logic             ret;
        logic             tail;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_nx;
        logic [1:0]       st_q;
        logic [1:0]       st_nx;
        logic             idle_q;
        logic             avail_q;

        assign sent = flit_valid_i[P] && (flit_vc_i[P*VC_SIZE +: VC_SIZE] == VC_SIZE'(V));
        assign ret  = credit_valid_i[P] && (credit_vc_i[P*VC_SIZE +: VC_SIZE] == VC_SIZE'(V));
        assign tail = flit_tail_i[P];

        // Counter saturates at both ends; a simultaneous send and return cancel out.
        always_comb begin
            cnt_nx = cnt_q;
            if (sent && !ret) begin
                if (cnt_q != '0) cnt_nx = cnt_q - ONE;
            end else if (ret && !sent) begin
                if (cnt_q != FULL) cnt_nx = cnt_q + ONE;
            end
        end

        always_comb begin
            st_nx = st_q;
            case (st_q)
                IDLE:     if (vc_alloc_i[d]) st_nx = ACTIVE;
                ACTIVE:   if (sent && tail) st_nx = (cnt_nx == FULL) ? IDLE : DRAINING;
                DRAINING: if (cnt_nx == FULL) st_nx = IDLE;
                default:  st_nx = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q    <= IDLE;
                cnt_q   <= FULL;
                idle_q  <= 1'b1;
                avail_q <= 1'b1;
            end else begin
                st_q    <= st_nx;
                cnt_q   <= cnt_nx;
                idle_q  <= (st_nx == IDLE);
                avail_q <= (cnt_nx != '0);
            end
        end

        assign idle_downstream_vc_o[d] = idle_q;
        assign credit_avail_o[d]       = avail_q;

`ifdef DOWNSTREAM_VC_TRACKER_ERR_EN
        assign vc_err[d] = (vc_alloc_i[d] && (st_q != IDLE))
                         || (sent && (st_q != ACTIVE))
                         || (sent && !ret && (cnt_q == '0))
                         || (ret && !sent && (cnt_q == FULL));
`endif
    end

`ifdef DOWNSTREAM_VC_TRACKER_ERR_EN
    logic error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) error_q <= 1'b0;
        else        error_q <= error_q | (|vc_err);
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_downstream_vc_tracker.sv
// Self-checking bench for downstream_vc_tracker: directed scenarios plus randomized
// traffic compared every cycle against an allocation/credit model kept in the bench.
module tb_downstream_vc_tracker;

    localparam int PN  = 5;
    localparam int VN  = 2;
    localparam int VT  = 10;
    localparam int BUF = 8;
`ifdef DOWNSTREAM_VC_TRACKER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [VT-1:0] alloc = '0;
    logic [PN-1:0] fv = '0, fvc = '0, ftail = '0, cv = '0, cvc = '0;
    logic [VT-1:0] idle, avail;
    logic          err;

    downstream_vc_tracker #(.PORT_NUM(PN), .VC_NUM(VN), .VC_TOTAL(VT), .BUFFER_SIZE(BUF)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .vc_alloc_i           (alloc),
        .flit_valid_i         (fv),
        .flit_vc_i            (fvc),
        .flit_tail_i          (ftail),
        .credit_valid_i       (cv),
        .credit_vc_i          (cvc),
        .idle_downstream_vc_o (idle),
        .credit_avail_o       (avail),
        .error_o              (err)
    );

    always #5 clk = ~clk;

    // Model: a VC is "allocated" from grant until its tail has gone and all credits are back.
    int            m_cnt[VT];
    bit            m_alloc[VT];
    bit            m_tail[VT];
    bit            m_err;
    logic [VT-1:0] e_idle, e_avail;
    logic          e_err;
    int            n_checks = 0;
    int            n_fail = 0;
    bit            chk_en = 1'b0;

    task automatic check(input string nm, input logic [VT-1:0] act, input logic [VT-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic update_exp();
        for (int d = 0; d < VT; d++) begin
            e_idle[d]  = !m_alloc[d];
            e_avail[d] = (m_cnt[d] != 0);
        end
        e_err = m_err;
    endtask

    task automatic model_reset();
        for (int d = 0; d < VT; d++) begin
            m_cnt[d]   = BUF;
            m_alloc[d] = 1'b0;
            m_tail[d]  = 1'b0;
        end
        m_err = 1'b0;
        update_exp();
    endtask

    task automatic model_step();
        bit viol;
        viol = 1'b0;
        for (int d = 0; d < VT; d++) begin
            int p, v, nc;
            bit s, r;
            p  = d / VN;
            v  = d % VN;
            s  = fv[p] && (int'(fvc[p]) == v);
            r  = cv[p] && (int'(cvc[p]) == v);
            nc = m_cnt[d] - int'(s) + int'(r);
            if (nc < 0)   begin nc = 0;   viol = 1'b1; end
            if (nc > BUF) begin nc = BUF; viol = 1'b1; end
            if (s && !(m_alloc[d] && !m_tail[d])) viol = 1'b1;
            if (alloc[d] && m_alloc[d]) viol = 1'b1;
            if (!m_alloc[d]) begin
                if (alloc[d]) begin
                    m_alloc[d] = 1'b1;
                    m_tail[d]  = 1'b0;
                end
            end else if (!m_tail[d] && s && ftail[p]) begin
                m_tail[d] = 1'b1;
            end
            if (m_alloc[d] && m_tail[d] && nc == BUF) begin
                m_alloc[d] = 1'b0;
                m_tail[d]  = 1'b0;
            end
            m_cnt[d] = nc;
        end
        m_err = m_err | (viol & ERR_EN);
        update_exp();
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #2;
        alloc = '0; fv = '0; fvc = '0; ftail = '0; cv = '0; cvc = '0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("idle_vs_model", idle, e_idle);
            check("avail_vs_model", avail, e_avail);
            check("error_vs_model", {9'b0, err}, {9'b0, e_err});
        end
    end

    task automatic rand_cycle(input bit allow_bad);
        for (int p = 0; p < PN; p++) begin
            int v, d;
            v = int'($urandom_range(0, VN - 1));
            d = p * VN + v;
            if (m_alloc[d] && !m_tail[d] && m_cnt[d] > 0 && $urandom_range(0, 3) != 0) begin
                fv[p] = 1'b1; fvc[p] = v[0]; ftail[p] = ($urandom_range(0, 3) == 0);
            end else if (allow_bad && $urandom_range(0, 49) == 0) begin
                fv[p] = 1'b1; fvc[p] = v[0]; ftail[p] = $urandom_range(0, 1) != 0;
            end
            v = int'($urandom_range(0, VN - 1));
            d = p * VN + v;
            if ((m_cnt[d] < BUF && $urandom_range(0, 1) != 0) ||
                (allow_bad && $urandom_range(0, 49) == 0)) begin
                cv[p] = 1'b1; cvc[p] = v[0];
            end
        end
        for (int d = 0; d < VT; d++) begin
            if ((!m_alloc[d] && $urandom_range(0, 7) == 0) ||
                (allow_bad && $urandom_range(0, 199) == 0))
                alloc[d] = 1'b1;
        end
        tick();
    endtask

    initial begin
        model_reset();
        #12;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Reset then quiet cycles
        repeat (3) tick();
        check("reset_idle", idle, 10'h3FF);
        check("reset_avail", avail, 10'h3FF);
        check("reset_error", {9'b0, err}, 10'h000);

        // Grant VC 3 (port 1, VC 1) and exhaust its credits
        alloc[3] = 1'b1;
        tick();
        check("alloc3_idle", idle, 10'h3F7);
        for (int i = 0; i < 8; i++) begin
            fv[1] = 1'b1; fvc[1] = 1'b1;
            tick();
            if (i == 6) check("seven_flits_avail", avail, 10'h3FF);
        end
        check("eight_flits_avail", avail, 10'h3F7);
        check("eight_flits_error", {9'b0, err}, 10'h000);

        // Refill to 5, tail with simultaneous credit, then drain
        repeat (5) begin
            cv[1] = 1'b1; cvc[1] = 1'b1;
            tick();
        end
        fv[1] = 1'b1; fvc[1] = 1'b1; ftail[1] = 1'b1; cv[1] = 1'b1; cvc[1] = 1'b1;
        tick();
        check("tail_drain_idle", idle, 10'h3F7);
        for (int i = 0; i < 3; i++) begin
            cv[1] = 1'b1; cvc[1] = 1'b1;
            tick();
            if (i == 1) check("drain_two_credits_idle", idle, 10'h3F7);
        end
        check("drain_done_idle", idle, 10'h3FF);
        check("drain_done_error", {9'b0, err}, 10'h000);

        // Every port sends and gets a credit on its VC 0 in the same cycle
        alloc = 10'b01_0101_0101;
        tick();
        check("alloc_even_idle", idle, 10'h2AA);
        fv = 5'b11111; cv = 5'b11111;
        tick();
        check("send_ret_avail", avail, 10'h3FF);
        check("send_ret_idle", idle, 10'h2AA);
        check("send_ret_error", {9'b0, err}, 10'h000);

        // Re-grant VC 0 while it is ACTIVE
        alloc[0] = 1'b1;
        tick();
        check("bad_alloc_error", {9'b0, err}, {9'b0, ERR_EN});
        check("bad_alloc_idle", idle, 10'h2AA);
        tick();
        check("bad_alloc_error_held", {9'b0, err}, {9'b0, ERR_EN});

        for (int i = 0; i < 1500; i++) rand_cycle(1'b0);
        for (int i = 0; i < 500; i++) rand_cycle(1'b1);

        // Clean reset, then build VC 7 (port 3, VC 1) draining with 2 credits
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        alloc[7] = 1'b1;
        tick();
        repeat (5) begin
            fv[3] = 1'b1; fvc[3] = 1'b1;
            tick();
        end
        fv[3] = 1'b1; fvc[3] = 1'b1; ftail[3] = 1'b1;
        tick();
        check("vc7_drain_idle", idle, 10'h37F);
        check("vc7_drain_avail", avail, 10'h3FF);

        // Asynchronous reset in the middle of the clock period
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_idle", idle, 10'h3FF);
        check("async_reset_avail", avail, 10'h3FF);
        check("async_reset_error", {9'b0, err}, 10'h000);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_reset_idle", idle, 10'h3FF);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
